// File: rtl/dm_pkg.sv
// Shared definitions for the debug-memory region: address map anchors,
// requester indices and the access-controller state encoding.
package dm_pkg;

    localparam logic [11:0] DM_HALTED_ADDR    = 12'h100;
    localparam logic [11:0] DM_RESUMEACK_ADDR = 12'h10C;
    localparam logic [11:0] DM_RAM_BASE       = 12'h400;
    localparam logic [11:0] DM_ROM_BASE       = 12'h800;

    typedef enum logic [1:0] {
        REQ_DM     = 2'd0,
        REQ_LSU    = 2'd1,
        REQ_IFETCH = 2'd2
    } req_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/dm_rr_arb3.sv
// Three-way round-robin arbiter; the requester after the last winner has
// top priority, and the pointer advances only when a grant is taken.
module dm_rr_arb3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] valid,
    input  logic       en,
    output logic [2:0] gnt,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] ptr;
    logic [1:0] sec;
    logic [1:0] thd;

    always_comb begin
        sec = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        thd = (sec == 2'd2) ? 2'd0 : sec + 2'd1;
        any = |valid;
        if (valid[ptr]) begin
            idx = ptr;
        end else if (valid[sec]) begin
            idx = sec;
        end else begin
            idx = thd;
        end
        gnt = any ? (3'b001 << idx) : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (en && any) begin
            ptr <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

endmodule

// File: rtl/dm_debug_mem_arb.sv
// Debug-memory region controller: arbitrates DM/LSU/IFETCH, sequences the
// external sync-read ROM, hosts the debug RAM and decodes halt/resume flags.
// Optional error reporting is enabled with `define DM_DEBUG_MEM_ERR_EN.
module dm_debug_mem_arb
    import dm_pkg::*;
#(
    parameter int ROM_WORDS = 29,
    parameter int RAM_WORDS = 7,
    parameter int ADDR_W    = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [2:0]          req_we,
    input  logic [95:0]         req_wdata,
    output logic [2:0]          rsp_valid,
    input  logic [2:0]          rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic [4:0]          rom_addr,
    input  logic [31:0]         rom_dout,
    output logic                halted_pulse,
    output logic [31:0]         halted_hartid,
    output logic                resumeack_pulse,
`ifdef DM_DEBUG_MEM_ERR_EN
    output logic                rsp_err,
`endif
    output logic [1:0]          fsm_state
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam logic [ADDR_W-1:0] RAM_B     = ADDR_W'(DM_RAM_BASE);
    localparam logic [ADDR_W-1:0] ROM_B     = ADDR_W'(DM_ROM_BASE);
    localparam logic [ADDR_W-3:0] RAM_LIMIT = (ADDR_W-2)'(RAM_WORDS);
    localparam logic [ADDR_W-3:0] ROM_LIMIT = (ADDR_W-2)'(ROM_WORDS);

    // Handshakes: a request transfers in the cycle req_valid[i] & req_ready[i];
    // a response transfers in the cycle rsp_valid[i] & rsp_ready[i], and
    // rsp_rdata is held stable from rsp_valid until that transfer.

    state_e state, state_nx;

    logic [2:0]        gnt;
    logic [1:0]        gnt_idx;
    logic              gnt_any;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [31:0]       sel_wdata;

    logic [1:0]        idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic              first_q;
    logic [31:0]       data_q;
    logic [31:0]       ram [0:RAM_WORDS-1];

    logic              aligned;
    logic [ADDR_W-3:0] ram_word;
    logic [ADDR_W-3:0] rom_word;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_ram;
    logic              is_rom;
    logic              is_halted;
    logic              is_resack;
    logic              rd_rom;
    logic [2:0]        idx_onehot;
    logic              resp_done;

    dm_rr_arb3 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .en    (state == ST_IDLE),
        .gnt   (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign sel_addr  = ({ADDR_W{gnt[0]}} & req_addr[0 +: ADDR_W])
                     | ({ADDR_W{gnt[1]}} & req_addr[ADDR_W +: ADDR_W])
                     | ({ADDR_W{gnt[2]}} & req_addr[2*ADDR_W +: ADDR_W]);
    // Instruction fetch never writes, whatever its we bit says.
    assign sel_we    = |(req_we & gnt & 3'b011);
    assign sel_wdata = ({32{gnt[0]}} & req_wdata[31:0])
                     | ({32{gnt[1]}} & req_wdata[63:32])
                     | ({32{gnt[2]}} & req_wdata[95:64]);

    assign aligned   = (addr_q[1:0] == 2'b00);
    assign ram_word  = addr_q[ADDR_W-1:2] - RAM_B[ADDR_W-1:2];
    assign rom_word  = addr_q[ADDR_W-1:2] - ROM_B[ADDR_W-1:2];
    assign ram_idx   = ram_word[RAM_AW-1:0];
    assign is_ram    = aligned && (addr_q >= RAM_B) && (ram_word < RAM_LIMIT);
    assign is_rom    = aligned && (addr_q >= ROM_B) && (rom_word < ROM_LIMIT);
    assign is_halted = (addr_q == ADDR_W'(DM_HALTED_ADDR));
    assign is_resack = (addr_q == ADDR_W'(DM_RESUMEACK_ADDR));
    assign rd_rom    = !we_q && is_rom;

    assign idx_onehot = 3'b001 << idx_q;
    assign resp_done  = (rsp_ready & idx_onehot) != 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx_q    <= 2'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rom_addr <= 5'd0;
            first_q  <= 1'b0;
            data_q   <= '0;
            for (int i = 0; i < RAM_WORDS; i++) begin
                ram[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && gnt_any) begin
                idx_q    <= gnt_idx;
                addr_q   <= sel_addr;
                we_q     <= sel_we;
                wdata_q  <= sel_wdata;
                rom_addr <= sel_addr[6:2];
            end
            if (state == ST_ACCESS) begin
                if (we_q && is_ram) begin
                    ram[ram_idx] <= wdata_q;
                end
                data_q  <= (!we_q && is_ram) ? ram[ram_idx] : 32'd0;
                first_q <= 1'b1;
            end
            if (state == ST_RESP) begin
                first_q <= 1'b0;
                // ROM data arrives in the first RESP cycle; keep it for stalls.
                if (resp_done) begin
                    data_q <= '0;
                end else if (first_q && rd_rom) begin
                    data_q <= rom_dout;
                end
            end
        end
    end

    always_comb begin
        state_nx        = state;
        req_ready       = 3'b000;
        rsp_valid       = 3'b000;
        halted_pulse    = 1'b0;
        resumeack_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_any && !rst) begin
                    req_ready = gnt;
                    state_nx  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                halted_pulse    = we_q && is_halted;
                resumeack_pulse = we_q && is_resack;
                state_nx        = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = idx_onehot;
                if (resp_done) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign rsp_rdata     = (state == ST_RESP && first_q && rd_rom) ? rom_dout : data_q;
    assign halted_hartid = halted_pulse ? wdata_q : 32'd0;
    assign fsm_state     = state;

`ifdef DM_DEBUG_MEM_ERR_EN
    logic access_err;
    assign access_err = !(is_ram || is_rom || is_halted || is_resack)
                      || (we_q && is_rom)
                      || (!we_q && (is_halted || is_resack));
    assign rsp_err    = (state == ST_RESP) && access_err;
`endif

endmodule

// File: tb/tb_dm_debug_mem_arb.sv
// Scoreboard bench for dm_debug_mem_arb with a behavioural sync-read ROM.
// Build with DM_DEBUG_MEM_ERR_EN defined to also check rsp_err.
`timescale 1ns/1ps
module tb_dm_debug_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [11:0] a_arr [3];
    logic [31:0] d_arr [3];
    logic [35:0] req_addr;
    logic [2:0]  req_we;
    logic [95:0] req_wdata;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rom_addr;
    logic [31:0] rom_dout = 32'd0;
    logic        halted_pulse;
    logic [31:0] halted_hartid;
    logic        resumeack_pulse;
    logic [1:0]  fsm_state;
`ifdef DM_DEBUG_MEM_ERR_EN
    logic        rsp_err;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [34:0] exp_q [$];
    int          cyc_q [$];
    logic [2:0]  gnt_exp_q [$];
    logic [34:0] head;
    bit          seen = 1'b0;
    bit          gnt_have_last = 1'b0;
    int          gnt_last = 0;
    int          halted_cnt = 0;
    int          resack_cnt = 0;
    logic [31:0] exp_hartid = 32'd0;

    assign req_addr  = {a_arr[2], a_arr[1], a_arr[0]};
    assign req_wdata = {d_arr[2], d_arr[1], d_arr[0]};

    dm_debug_mem_arb dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_we          (req_we),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rom_addr        (rom_addr),
        .rom_dout        (rom_dout),
        .halted_pulse    (halted_pulse),
        .halted_hartid   (halted_hartid),
        .resumeack_pulse (resumeack_pulse),
`ifdef DM_DEBUG_MEM_ERR_EN
        .rsp_err         (rsp_err),
`endif
        .fsm_state       (fsm_state)
    );

    // Clock / reset-free housekeeping
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ROM model: word 0 = 0x0000006F, word i = 0x10000000 | i
    always @(posedge clk) begin
        rom_dout <= (rom_addr == 5'd0) ? 32'h0000006F : {4'h1, 23'd0, rom_addr};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Driver: caller is at a negedge; holds the request until accepted.
    task automatic issue(input int idx, input logic [11:0] a, input logic w,
                         input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        int n;
        a_arr[idx]     = a;
        d_arr[idx]     = d;
        req_we[idx]    = w;
        req_valid[idx] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[idx] && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant", {31'd0, req_ready[idx]}, 32'd1);
        if (req_ready[idx]) begin
            exp_q.push_back({exp_e, 2'(idx), exp_d});
            cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        req_we[idx]    = 1'b0;
    endtask

    task automatic issue_n(input int idx, input logic [11:0] a, input logic w,
                           input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        issue(idx, a, w, d, exp_d, exp_e);
    endtask

    task automatic wait_rsp(input int idx);
        int n = 0;
        while (!rsp_valid[idx] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_wait", {31'd0, rsp_valid[idx]}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && rsp_valid != 3'b000) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=%b, required no response", rsp_valid);
            end else begin
                head = exp_q[0];
                if (!seen) begin
                    chk("rsp_latency", cyc - cyc_q[0], 32'd2);
                    seen = 1'b1;
                end
                chk("rsp_onehot", {29'd0, rsp_valid}, 32'd1 << head[33:32]);
                chk("rsp_rdata", rsp_rdata, head[31:0]);
                chk("req_ready_busy", {29'd0, req_ready}, 32'd0);
                if ((rsp_valid & rsp_ready) != 3'b000) begin
`ifdef DM_DEBUG_MEM_ERR_EN
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, head[34]});
`endif
                    void'(exp_q.pop_front());
                    void'(cyc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Grant-order monitor
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (req_ready != 3'b000 && gnt_exp_q.size() > 0) begin
                chk("grant_order", {29'd0, req_ready}, {29'd0, gnt_exp_q.pop_front()});
                if (gnt_have_last) chk("grant_spacing", cyc - gnt_last, 32'd3);
                gnt_last      = cyc;
                gnt_have_last = (gnt_exp_q.size() > 0);
            end
        end
    end

    // Flag-pulse monitor
    always @(negedge clk) begin
        if (halted_pulse) begin
            halted_cnt++;
            chk("halted_hartid", halted_hartid, exp_hartid);
        end
        if (resumeack_pulse) resack_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_ready = 3'b111;
        req_valid = 3'b111;
        req_we    = 3'b000;
        a_arr[0]  = 12'h404;
        a_arr[1]  = 12'h804;
        a_arr[2]  = 12'h808;
        for (int i = 0; i < 3; i++) d_arr[i] = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {29'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_halted_pulse", {31'd0, halted_pulse}, 32'd0);
        chk("rst_resack_pulse", {31'd0, resumeack_pulse}, 32'd0);
        chk("rst_hartid", halted_hartid, 32'd0);
        chk("rst_rom_addr", {27'd0, rom_addr}, 32'd0);
        chk("rst_state", {30'd0, fsm_state}, 32'd0);
`ifdef DM_DEBUG_MEM_ERR_EN
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
`endif

        // Round robin with all requesters pending out of reset
        gnt_exp_q.push_back(3'b001);
        gnt_exp_q.push_back(3'b010);
        gnt_exp_q.push_back(3'b100);
        gnt_exp_q.push_back(3'b001);
        @(negedge clk);
        rst = 1'b0;
        fork
            begin
                issue(0, 12'h404, 1'b0, 32'd0, 32'd0, 1'b0);
                @(negedge clk);
                issue(0, 12'h418, 1'b0, 32'd0, 32'd0, 1'b0);
            end
            issue(1, 12'h804, 1'b0, 32'd0, 32'h10000001, 1'b0);
            issue(2, 12'h808, 1'b0, 32'd0, 32'h10000002, 1'b0);
        join
        drain();
        chk("rom_addr_hold", {27'd0, rom_addr}, 32'd6);

        // ROM fetch, RAM write-then-read, ignored writes
        issue_n(2, 12'h800, 1'b0, 32'd0, 32'h0000006F, 1'b0);
        issue_n(0, 12'h418, 1'b1, 32'hDEADBEEF, 32'd0, 1'b0);
        issue_n(1, 12'h418, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0);
        issue_n(2, 12'h400, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0);
        issue_n(0, 12'h400, 1'b0, 32'd0, 32'd0, 1'b0);
        issue_n(0, 12'h800, 1'b1, 32'h12345678, 32'd0, 1'b1);
        issue_n(1, 12'h800, 1'b0, 32'd0, 32'h0000006F, 1'b0);
        drain();

        // Flag writes
        exp_hartid = 32'd0;
        issue_n(1, 12'h100, 1'b1, 32'd0, 32'd0, 1'b0);
        drain();
        issue_n(1, 12'h10C, 1'b1, 32'd0, 32'd0, 1'b0);
        drain();
        exp_hartid = 32'd5;
        issue_n(1, 12'h100, 1'b1, 32'd5, 32'd0, 1'b0);
        drain();
        chk("halted_count", halted_cnt, 32'd2);
        chk("resack_count", resack_cnt, 32'd1);

        // Response back-pressure with a competing request
        rsp_ready[1] = 1'b0;
        fork
            issue_n(1, 12'h418, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0);
            begin
                repeat (3) @(negedge clk);
                issue(0, 12'h418, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0);
            end
            begin
                wait_rsp(1);
                repeat (5) @(posedge clk);
                #1;
                rsp_ready[1] = 1'b1;
            end
        join
        drain();

        // Unmapped, misaligned, flag-read, past-end ROM and aliasing checks
        issue_n(1, 12'h200, 1'b0, 32'd0, 32'd0, 1'b1);
        issue_n(1, 12'h402, 1'b0, 32'd0, 32'd0, 1'b1);
        issue_n(1, 12'h100, 1'b0, 32'd0, 32'd0, 1'b1);
        issue_n(1, 12'h874, 1'b0, 32'd0, 32'd0, 1'b1);
        issue_n(0, 12'h41C, 1'b1, 32'hCAFEF00D, 32'd0, 1'b1);
        issue_n(1, 12'h41C, 1'b0, 32'd0, 32'd0, 1'b1);
        issue_n(1, 12'h870, 1'b0, 32'd0, 32'h1000001C, 1'b0);
        drain();

        // Reset during RESP aborts the response, clears RAM and the pointer
        rsp_ready[0] = 1'b0;
        issue_n(0, 12'h404, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_rsp(0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", {29'd0, rsp_valid}, 32'd0);
        chk("abort_state", {30'd0, fsm_state}, 32'd0);
        chk("abort_req_ready", {29'd0, req_ready}, 32'd0);
        exp_q.delete();
        cyc_q.delete();
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 3'b111;
        gnt_exp_q.push_back(3'b001);
        gnt_exp_q.push_back(3'b010);
        @(negedge clk);
        fork
            issue(1, 12'h418, 1'b0, 32'd0, 32'd0, 1'b0);
            issue(0, 12'h418, 1'b0, 32'd0, 32'd0, 1'b0);
        join
        drain();
        chk("abort_no_pulse", halted_cnt + resack_cnt, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
